fetch_sequencer: RTL and testbench

Fetch-stage controller that owns the program counter and sequences instruction fetches over a request/grant/response memory interface. It presents fetched instructions to decode with a valid/ready handshake and applies branch/jump redirects from execute. It sits between the instruction memory and the decode stage of the RV32I core, replacing free-running PC increment with a stall- and redirect-aware sequencer.

---
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC and issues one outstanding imem fetch at a time.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
//
// state    | meaning
// ---------+------------------------------------------------
// BOOT     | one idle cycle after reset, no request
// ISSUE    | imem_req high at pc, waiting for grant
// WAIT_RSP | request granted, waiting for response
// HOLD     | instruction presented to decode until dec_ready
// DRAIN    | discarding a response that belongs to a stale path
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        dec_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped,
`endif
   output logic        fetch_misaligned
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_ISSUE,
      S_WAIT_RSP,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_fetch_done;
   logic [31:0] r_pc;
   logic        r_imem_req;
   logic        r_instr_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        r_misaligned;

   always_comb begin
      w_state_nxt  = r_state;
      w_fetch_done = 1'b0;
      case (r_state)
         S_BOOT: w_state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (imem_gnt)
               w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            if (redirect_valid)
               w_state_nxt = imem_rvalid ? S_ISSUE : S_DRAIN;
            else if (imem_rvalid)
               w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            w_fetch_done = dec_ready;
            if (redirect_valid || dec_ready)
               w_state_nxt = S_ISSUE;
         end
         S_DRAIN: begin
            if (imem_rvalid)
               w_state_nxt = S_ISSUE;
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   // Redirect overrides both capture and PC advance; the request flag follows the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_VECTOR;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_instr       <= NOP_INSTR;
         r_instr_pc    <= 32'h0;
         r_misaligned  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_imem_req   <= (w_state_nxt == S_ISSUE);
         r_misaligned <= redirect_valid && (redirect_target[1:0] != 2'b00);
         if (redirect_valid) begin
            r_pc          <= {redirect_target[31:2], 2'b00};
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
         end else if (r_state == S_WAIT_RSP && imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
         end else if (w_fetch_done) begin
            r_pc          <= r_pc + 32'd4;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic        w_drop;
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_dropped;

   assign w_drop = imem_rvalid &&
                   ((r_state == S_DRAIN) || (r_state == S_WAIT_RSP && redirect_valid));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetched <= 32'h0;
         r_perf_dropped <= 32'h0;
      end else begin
         if (w_fetch_done)
            r_perf_fetched <= r_perf_fetched + 32'd1;
         if (w_drop)
            r_perf_dropped <= r_perf_dropped + 32'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_dropped = r_perf_dropped;
`endif

   assign imem_req         = r_imem_req;
   assign imem_addr        = r_pc;
   assign instr_valid      = r_instr_valid;
   assign instr            = r_instr;
   assign instr_pc         = r_instr_pc;
   assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected grant addresses and decode handshakes
// are queued by the stimulus and popped by independent monitors.
module tb_fetch_sequencer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        dec_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        fetch_misaligned;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   int n_cmp   = 0;
   int n_err   = 0;
   int cyc_n   = 0;
   int hs_cnt  = 0;
   int hs_prev = 0;
   int hs_last = 0;
   int rsp_lat = 1;

   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_ins_q[$];

   fetch_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_gnt         (imem_gnt),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .instr_valid      (instr_valid),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .dec_ready        (dec_ready),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
`ifdef FETCH_PERF_EN
      .perf_fetched     (perf_fetched),
      .perf_dropped     (perf_dropped),
`endif
      .fetch_misaligned (fetch_misaligned)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A00_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_fetch(input logic [31:0] a);
      exp_ins_q.push_back({a, mem_word(a)});
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!instr_valid && t < 50) begin
         cyc(1);
         t++;
      end
      check("wait_valid", {31'h0, instr_valid}, 32'h1);
   endtask

   task automatic run_n(input int n);
      int tgt;
      int t;
      tgt = hs_cnt + n;
      t = 0;
      imem_gnt  = 1'b1;
      dec_ready = 1'b1;
      while (hs_cnt < tgt && t < 100) begin
         cyc(1);
         t++;
      end
      imem_gnt  = 1'b0;
      dec_ready = 1'b0;
      check("handshake_count", hs_cnt, tgt);
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
   endtask

   // Memory responder: rvalid rsp_lat cycles after each grant, data derived from address.
   initial begin
      logic [31:0] a;
      int lat;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset && imem_req && imem_gnt) begin
            a   = imem_addr;
            lat = rsp_lat;
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1;
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(a);
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && imem_req && imem_gnt) begin
            if (exp_addr_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_grant: got addr %h expected no grant", imem_addr);
            end else begin
               check("grant_addr", imem_addr, exp_addr_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!reset && instr_valid && dec_ready) begin
            if (exp_ins_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_handshake: got pc %h expected none", instr_pc);
            end else begin
               e = exp_ins_q.pop_front();
               check("hs_instr_pc", instr_pc, e[63:32]);
               check("hs_instr", instr, e[31:0]);
            end
            hs_cnt++;
            hs_prev = hs_last;
            hs_last = cyc_n;
         end
      end
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      imem_gnt        = 1'b0;
      dec_ready       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      cyc(10);
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr", instr, NOP);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_misaligned", {31'h0, fetch_misaligned}, 32'h0);
      reset = 1'b0;

      // Back-to-back fetches at full rate.
      foreach (exp_addr_q[i]) ;
      exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
      exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
      run_n(3);
      check("throughput", hs_last - hs_prev, 32'd3);
      check("next_req", {31'h0, imem_req}, 32'h1);
      check("next_addr", imem_addr, 32'hC);

      // Decode stall: instruction and outputs held.
      exp_addr_q.push_back(32'hC);
      exp_fetch(32'hC);
      imem_gnt = 1'b1;
      wait_valid();
      imem_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'h0, instr_valid}, 32'h1);
         check("hold_pc", instr_pc, 32'hC);
         check("hold_instr", instr, mem_word(32'hC));
         check("hold_req", {31'h0, imem_req}, 32'h0);
         cyc(1);
      end

      // Redirect while waiting for a response; late response is dropped.
      rsp_lat = 2;
      exp_addr_q.push_back(32'h10);
      imem_gnt  = 1'b1;
      dec_ready = 1'b1;
      cyc(1);
      dec_ready = 1'b0;
      cyc(1);
      redirect_valid  = 1'b1;
      redirect_target = 32'h170;
      cyc(1);
      redirect_valid = 1'b0;
      check("drain_misaligned", {31'h0, fetch_misaligned}, 32'h0);
      check("drain_valid", {31'h0, instr_valid}, 32'h0);
      check("drain_req", {31'h0, imem_req}, 32'h0);
      rsp_lat = 1;
      cyc(1);
      exp_addr_q.push_back(32'h170); exp_addr_q.push_back(32'h174);
      exp_fetch(32'h170); exp_fetch(32'h174);
      check("post_drain_req", {31'h0, imem_req}, 32'h1);
      check("post_drain_addr", imem_addr, 32'h170);
      run_n(2);

      // Misaligned redirect while ISSUE is not granted.
      redirect_valid  = 1'b1;
      redirect_target = 32'h202;
      cyc(1);
      redirect_valid = 1'b0;
      check("misaligned_pulse", {31'h0, fetch_misaligned}, 32'h1);
      check("misaligned_addr", imem_addr, 32'h200);
      check("misaligned_req", {31'h0, imem_req}, 32'h1);
      exp_addr_q.push_back(32'h200);
      exp_fetch(32'h200);
      cyc(1);
      check("misaligned_clear", {31'h0, fetch_misaligned}, 32'h0);
      check("misaligned_addr_hold", imem_addr, 32'h200);
      run_n(1);

      // PC wrap from the top of the address space.
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      cyc(1);
      redirect_valid = 1'b0;
      exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
      exp_fetch(32'hFFFF_FFFC); exp_fetch(32'h0);
      run_n(2);

      // Redirect in the same cycle as a grant: that response is drained.
      exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h300);
      exp_fetch(32'h300);
      imem_gnt        = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h300;
      cyc(1);
      redirect_valid = 1'b0;
      check("gnt_redir_req", {31'h0, imem_req}, 32'h0);
      check("gnt_redir_valid", {31'h0, instr_valid}, 32'h0);
      run_n(1);

      // Redirect coinciding with a decode handshake in HOLD.
      exp_addr_q.push_back(32'h304);
      exp_fetch(32'h304);
      imem_gnt = 1'b1;
      wait_valid();
      imem_gnt        = 1'b0;
      dec_ready       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h400;
      cyc(1);
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      check("hold_redir_valid", {31'h0, instr_valid}, 32'h0);
      check("hold_redir_instr", instr, NOP);
      check("hold_redir_req", {31'h0, imem_req}, 32'h1);
      check("hold_redir_addr", imem_addr, 32'h400);
      exp_addr_q.push_back(32'h400);
      exp_fetch(32'h400);
      run_n(1);

      // Reset while waiting for a response; response lands in BOOT.
      exp_addr_q.push_back(32'h404);
      rsp_lat  = 2;
      imem_gnt = 1'b1;
      cyc(1);
      imem_gnt = 1'b0;
      reset    = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("mid_rst_req", {31'h0, imem_req}, 32'h0);
      check("mid_rst_addr", imem_addr, 32'h0);
      check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
      rsp_lat = 1;
      exp_addr_q.push_back(32'h0);
      exp_fetch(32'h0);
      cyc(1);
      check("boot_rsp_req", {31'h0, imem_req}, 32'h1);
      check("boot_rsp_addr", imem_addr, 32'h0);
      check("boot_rsp_valid", {31'h0, instr_valid}, 32'h0);
      run_n(1);

      cyc(3);
      check("addr_q_left", exp_addr_q.size(), 32'h0);
      check("instr_q_left", exp_ins_q.size(), 32'h0);
      summary();
      $finish;
   end

endmodule
